sprite_renderer: RTL and testbench

- Pixel stage directly downstream of the VGA timing generator.
- Consumes the generator's h_pos, v_pos, display_on, h_sync and v_sync, and draws one animated 32x32 sushi sprite over a flat background.
- The sprite bounces off the screen edges and moves once per frame, only during vertical blanking, so it never tears.
- Outputs registered 12-bit RGB plus delayed sync and data-enable signals, all aligned to the RGB.

---
 rtl/sushi_vga_pkg.sv | 66 ++++++
 rtl/sushi_sprite_rom.sv | 24 ++
 rtl/sprite_renderer.sv | 137 +++++++++++++
 tb/tb_sprite_renderer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sushi_vga_pkg.sv
// Shared constants, types and helpers for the sushi sprite pixel stage.
// Screen and sprite geometry, the palette, the sprite shape and the bounce step.
package sushi_vga_pkg;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned SPRITE_W  = 32;
  localparam int unsigned SPRITE_H  = 32;
  localparam int unsigned SPR_XW    = $clog2(SPRITE_W);
  localparam int unsigned SPR_YW    = $clog2(SPRITE_H);
  localparam int unsigned ROM_AW    = 1 + SPR_YW + SPR_XW;

  typedef logic [11:0] rgb444_t;

  typedef struct packed {
    logic hit;
    logic de;
    logic hs;
    logic vs;
  } pix_ctrl_t;

  // Entry 0 is never displayed: index 0 marks a transparent sprite pixel.
  localparam rgb444_t PALETTE [8] = '{
    12'h000, 12'hFFE, 12'h132, 12'hF74, 12'hFA8, 12'h6B3, 12'hE22, 12'hFD0
  };

  // Sushi shape: salmon topping (colour alternates per animation frame),
  // rice body with a nori band, transparent margins.
  function automatic logic [2:0] sprite_pixel(input logic anim, input logic [4:0] y,
                                              input logic [4:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    if (y < 5'd8) begin
      if (x >= 5'd4 && x < 5'd28) idx = anim ? 3'd4 : 3'd3;
    end else if (y < 5'd28) begin
      if (x >= 5'd2 && x < 5'd30) idx = (x >= 5'd14 && x < 5'd18) ? 3'd2 : 3'd1;
    end
    return idx;
  endfunction

  // One bounce step on an axis; returns {new_negative_dir, new_pos}.
  function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic neg,
                                            input logic [9:0] lim, input logic [9:0] speed);
    logic [10:0] sum;
    logic [9:0]  npos;
    logic        nneg;
    sum  = {1'b0, pos} + {1'b0, speed};
    npos = pos;
    nneg = neg;
    if (!neg) begin
      if (sum >= {1'b0, lim}) begin
        npos = lim;
        nneg = 1'b1;
      end else begin
        npos = sum[9:0];
      end
    end else if (pos < speed) begin
      npos = '0;
      nneg = 1'b0;
    end else begin
      npos = pos - speed;
    end
    return {nneg, npos};
  endfunction

endpackage

// File: rtl/sushi_sprite_rom.sv
// Sprite colour-index ROM, 2 frames x 32x32 x 3 bits, synchronous read.
// Contents are produced by the shape function in the package.
module sushi_sprite_rom
  import sushi_vga_pkg::*;
(
  input  logic              clk_i,
  input  logic [ROM_AW-1:0] addr_i,
  output logic [2:0]        data_o
);

  logic [2:0] data_q;
  logic [2:0] data_d;

  always_comb begin
    data_d = sprite_pixel(addr_i[ROM_AW-1], addr_i[SPR_XW+SPR_YW-1:SPR_XW], addr_i[SPR_XW-1:0]);
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/sprite_renderer.sv
// Pixel stage after the VGA timing generator: draws a bouncing, animated sushi
// sprite over a flat background with a fixed 3-cycle pixel/sync latency.
module sprite_renderer
  import sushi_vga_pkg::*;
#(
  parameter int unsigned INIT_X    = 100,
  parameter int unsigned INIT_Y    = 80,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned ANIM_DIV  = 15,
  parameter rgb444_t     BG_COLOR  = 12'h235,
  parameter bit          INIT_LEFT = 1'b0,
  parameter bit          INIT_UP   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_pos,
  input  logic [9:0]  v_pos,
  input  logic        display_on,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        pause,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out
);

  localparam int unsigned CNT_W   = $clog2(ANIM_DIV + 1);
  localparam logic [9:0]  X_MAX   = 10'(H_DISPLAY - SPRITE_W);
  localparam logic [9:0]  Y_MAX   = 10'(V_DISPLAY - SPRITE_H);
  localparam logic [9:0]  SPEED_V = 10'(SPEED);

  logic [9:0]       sprite_x_q, sprite_x_d, sprite_y_q, sprite_y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;  // 1 = left / up
  logic             anim_q, anim_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  pix_ctrl_t         s1_q, s1_d, s2_q, s2_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  rgb444_t           rgb_q, rgb_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;

  logic       frame_tick;
  logic [9:0] dx, dy;
  logic [2:0] rom_idx;

  assign frame_tick = (h_pos == 10'd0) && (v_pos == 10'(V_DISPLAY));

  // Wrap-around makes pixels left of / above the sprite huge, failing the hit test.
  always_comb begin
    dx         = h_pos - sprite_x_q;
    dy         = v_pos - sprite_y_q;
    s1_d.hit   = (dx < 10'(SPRITE_W)) && (dy < 10'(SPRITE_H));
    s1_d.de    = display_on;
    s1_d.hs    = h_sync;
    s1_d.vs    = v_sync;
    rom_addr_d = {anim_q, dy[SPR_YW-1:0], dx[SPR_XW-1:0]};
    s2_d       = s1_q;
  end

  always_comb begin
    if (!s2_q.de) begin
      rgb_d = '0;
    end else if (s2_q.hit && rom_idx != 3'd0) begin
      rgb_d = PALETTE[rom_idx];
    end else begin
      rgb_d = BG_COLOR;
    end
    hsync_d = s2_q.hs;
    vsync_d = s2_q.vs;
    de_d    = s2_q.de;
  end

  // Sprite state moves only on the first blanking line, so a frame never tears.
  always_comb begin
    sprite_x_d  = sprite_x_q;
    sprite_y_d  = sprite_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    anim_d      = anim_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_tick && !pause) begin
      {dir_x_d, sprite_x_d} = axis_step(sprite_x_q, dir_x_q, X_MAX, SPEED_V);
      {dir_y_d, sprite_y_d} = axis_step(sprite_y_q, dir_y_q, Y_MAX, SPEED_V);
      if (frame_cnt_q == CNT_W'(ANIM_DIV - 1)) begin
        frame_cnt_d = '0;
        anim_d      = ~anim_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sprite_x_q  <= 10'(INIT_X);
      sprite_y_q  <= 10'(INIT_Y);
      dir_x_q     <= INIT_LEFT;
      dir_y_q     <= INIT_UP;
      anim_q      <= 1'b0;
      frame_cnt_q <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      rom_addr_q  <= '0;
      rgb_q       <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      de_q        <= 1'b0;
    end else begin
      sprite_x_q  <= sprite_x_d;
      sprite_y_q  <= sprite_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      anim_q      <= anim_d;
      frame_cnt_q <= frame_cnt_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      rom_addr_q  <= rom_addr_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
    end
  end

  sushi_sprite_rom u_rom (
    .clk_i  (clk),
    .addr_i (rom_addr_q),
    .data_o (rom_idx)
  );

  assign rgb       = rgb_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;
  assign de_out    = de_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: expected pixels/syncs are queued at drive
// time from a local sprite model and compared three cycles later.
module tb_sprite_renderer;

  localparam logic [11:0] BG = 12'h235;
  localparam logic [11:0] PAL [8] = '{
    12'h000, 12'hFFE, 12'h132, 12'hF74, 12'hFA8, 12'h6B3, 12'hE22, 12'hFD0
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] h_pos = '0, v_pos = '0;
  logic       display_on = 1'b0, h_sync = 1'b0, v_sync = 1'b0, pause = 1'b0;
  logic [11:0] rgb, rgb_b, rgb_c;
  logic       hs_o, vs_o, de_o, hs_b, vs_b, de_b, hs_c, vs_c, de_c;

  always #5 clk = ~clk;

  sprite_renderer dut (
    .clk(clk), .rst(rst), .h_pos(h_pos), .v_pos(v_pos), .display_on(display_on),
    .h_sync(h_sync), .v_sync(v_sync), .pause(pause),
    .rgb(rgb), .hsync_out(hs_o), .vsync_out(vs_o), .de_out(de_o)
  );

  sprite_renderer #(.INIT_X(607)) dut_b (
    .clk(clk), .rst(rst), .h_pos(h_pos), .v_pos(v_pos), .display_on(display_on),
    .h_sync(h_sync), .v_sync(v_sync), .pause(pause),
    .rgb(rgb_b), .hsync_out(hs_b), .vsync_out(vs_b), .de_out(de_b)
  );

  sprite_renderer #(.INIT_X(0), .INIT_Y(0), .INIT_LEFT(1'b1), .INIT_UP(1'b1)) dut_c (
    .clk(clk), .rst(rst), .h_pos(h_pos), .v_pos(v_pos), .display_on(display_on),
    .h_sync(h_sync), .v_sync(v_sync), .pause(pause),
    .rgb(rgb_c), .hsync_out(hs_c), .vsync_out(vs_c), .de_out(de_c)
  );

  typedef struct {
    logic [11:0] rgb;
    logic        hs, vs, de;
    int          hp, vp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mx, my, manim, mcnt;
  bit   mleft, mup;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pix(input int anim, input int y, input int x);
    if (y < 8) return (x >= 4 && x < 28) ? (anim != 0 ? 4 : 3) : 0;
    if (y < 28) begin
      if (x < 2 || x >= 30) return 0;
      return (x >= 14 && x < 18) ? 2 : 1;
    end
    return 0;
  endfunction

  task automatic axis(inout int p, inout bit neg, input int lim);
    if (!neg) begin
      if (p + 2 >= lim) begin p = lim; neg = 1'b1; end
      else p = p + 2;
    end else begin
      if (p < 2) begin p = 0; neg = 1'b0; end
      else p = p - 2;
    end
  endtask

  task automatic model_reset();
    mx = 100; my = 80; mleft = 1'b0; mup = 1'b0; manim = 0; mcnt = 0;
  endtask

  task automatic drive(input int hp, input int vp, input bit de, input bit hs, input bit vs,
                       input bit pz);
    exp_t e;
    int dx, dy, idx;
    dx = (hp - mx) & 32'h3FF;
    dy = (vp - my) & 32'h3FF;
    idx = pix(manim, dy % 32, dx % 32);
    e.hs = hs; e.vs = vs; e.de = de; e.hp = hp; e.vp = vp;
    if (!de) e.rgb = 12'h000;
    else if (dx < 32 && dy < 32 && idx != 0) e.rgb = PAL[idx];
    else e.rgb = BG;
    sb.push_back(e);
    if (hp == 0 && vp == 480 && !pz) begin
      axis(mx, mleft, 608);
      axis(my, mup, 448);
      mcnt++;
      if (mcnt == 15) begin mcnt = 0; manim ^= 1; end
    end
    h_pos = 10'(hp); v_pos = 10'(vp);
    display_on = de; h_sync = hs; v_sync = vs; pause = pz;
    @(posedge clk);
    #1;
    if (sb.size() == 3) begin
      e = sb.pop_front();
      check_eq($sformatf("rgb@%0d,%0d", e.hp, e.vp), rgb, e.rgb);
      check_eq($sformatf("hsync@%0d,%0d", e.hp, e.vp), hs_o, e.hs);
      check_eq($sformatf("vsync@%0d,%0d", e.hp, e.vp), vs_o, e.vs);
      check_eq($sformatf("de@%0d,%0d", e.hp, e.vp), de_o, e.de);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    display_on = 1'b1; h_sync = 1'b1; v_sync = 1'b1;
    sb.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_eq("reset_rgb", rgb, 12'h000);
      check_eq("reset_hsync", hs_o, 1'b0);
      check_eq("reset_vsync", vs_o, 1'b0);
      check_eq("reset_de", de_o, 1'b0);
    end
    check_eq("reset_x", dut.sprite_x_q, 100);
    check_eq("reset_y", dut.sprite_y_q, 80);
    check_eq("reset_anim", dut.anim_q, 0);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic sweep_row(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) drive(x, y, 1'b1, (x % 7) == 0, (x % 5) == 1, 1'b0);
  endtask

  task automatic tick(input bit pz);
    drive(0, 480, 1'b0, 1'b0, 1'b1, pz);
  endtask

  initial begin
    model_reset();
    do_reset(5);

    // Sync alignment and basic pixels around the initial sprite corner.
    drive(700, 500, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(700, 500, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(700, 500, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(100, 80, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(99, 80, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(110, 90, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (sb[i]) ;
    sweep_row(80, 96, 134);
    sweep_row(84, 96, 134);
    sweep_row(95, 96, 134);
    sweep_row(111, 96, 134);
    sweep_row(112, 96, 134);
    sweep_row(79, 98, 104);

    // One frame tick: move and check the bounce instances.
    tick(1'b0);
    check_eq("tick1_x", dut.sprite_x_q, mx);
    check_eq("tick1_y", dut.sprite_y_q, my);
    check_eq("b_x_after_tick1", dut_b.sprite_x_q, 608);
    check_eq("b_dir_after_tick1", dut_b.dir_x_q, 1);
    check_eq("c_x_corner", dut_c.sprite_x_q, 0);
    check_eq("c_y_corner", dut_c.sprite_y_q, 0);
    check_eq("c_dirx_corner", dut_c.dir_x_q, 0);
    check_eq("c_diry_corner", dut_c.dir_y_q, 0);
    sweep_row(82, 100, 136);
    sweep_row(90, 100, 136);

    // Paused ticks change nothing.
    for (int i = 0; i < 3; i++) tick(1'b1);
    check_eq("pause_x", dut.sprite_x_q, 102);
    check_eq("pause_y", dut.sprite_y_q, 82);
    check_eq("pause_anim", dut.anim_q, 0);
    check_eq("pause_b_x", dut_b.sprite_x_q, 608);

    // Remaining 14 ticks complete one animation period.
    for (int i = 0; i < 14; i++) begin
      tick(1'b0);
      if (i == 0) check_eq("b_x_after_tick2", dut_b.sprite_x_q, 606);
    end
    check_eq("anim_x", dut.sprite_x_q, mx);
    check_eq("anim_y", dut.sprite_y_q, my);
    check_eq("anim_frame", dut.anim_q, manim);
    drive(mx + 5, my + 2, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("rom_addr_msb", dut.rom_addr_q[10], 1);
    sweep_row(my + 3, mx - 2, mx + 33);
    sweep_row(my + 20, mx - 2, mx + 33);

    // Mid-frame reset, then rendering resumes at the initial position.
    sweep_row(my + 1, mx, mx + 4);
    do_reset(2);
    sweep_row(80, 98, 134);
    sweep_row(100, 98, 134);
    drive(700, 500, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(700, 500, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
